// File: rtl/snake_pkg.sv
// Shared types for the snake body slice: directions, FSM states and
// default coordinate widths.
package snake_pkg;

  localparam int COORD_W_D = 5;
  localparam int SEG_W_D   = 2 * COORD_W_D;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_e;

  // up<->down and left<->right differ only in bit 1
  function automatic dir_e opposite(dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_body_if.sv
// Control/status bundle between the game controller and snake_body.
// master drives the controls, slave is the snake body.
interface snake_body_if
  import snake_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int COORD_W = COORD_W_D
);
  localparam int SEG_W = 2 * COORD_W;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                     start;
  logic                     tick;
  logic [1:0]               dir_req;
  logic                     grow;
  logic                     stop;
  logic [MAX_LEN*SEG_W-1:0] snake;
  logic [LEN_W-1:0]         len;
  logic                     alive;
  logic                     moved;

  modport master (
    output start, tick, dir_req, grow, stop,
    input  snake, len, alive, moved
  );

  modport slave (
    input  start, tick, dir_req, grow, stop,
    output snake, len, alive, moved
  );
endinterface

// File: rtl/snake_next_head.sv
// Combinational next-head step with field-edge handling.
// SNAKE_WRAP_EN defined: wrap at edges; undefined: flag leaving the field.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int COORD_W = COORD_W_D,
  parameter int FIELD_W = 30,
  parameter int FIELD_H = 24
) (
  input  logic [2*COORD_W-1:0] i_head,
  input  dir_e                 i_dir,
  output logic [2*COORD_W-1:0] o_head,
  output logic                 o_out
);
  localparam logic [COORD_W-1:0] XMAX = COORD_W'(FIELD_W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(FIELD_H - 1);

  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;
  logic [COORD_W-1:0] w_nx;
  logic [COORD_W-1:0] w_ny;
  logic               w_edge;

  assign w_x = i_head[COORD_W-1:0];
  assign w_y = i_head[2*COORD_W-1:COORD_W];

  always_comb begin
    w_nx   = w_x;
    w_ny   = w_y;
    w_edge = 1'b0;
    unique case (i_dir)
      DIR_UP: begin
        w_edge = (w_y == '0);
        w_ny   = w_edge ? YMAX : w_y - 1'b1;
      end
      DIR_RIGHT: begin
        w_edge = (w_x == XMAX);
        w_nx   = w_edge ? '0 : w_x + 1'b1;
      end
      DIR_DOWN: begin
        w_edge = (w_y == YMAX);
        w_ny   = w_edge ? '0 : w_y + 1'b1;
      end
      DIR_LEFT: begin
        w_edge = (w_x == '0);
        w_nx   = w_edge ? XMAX : w_x - 1'b1;
      end
    endcase
  end

  assign o_head = {w_ny, w_nx};

`ifdef SNAKE_WRAP_EN
  assign o_out = 1'b0;
`else
  assign o_out = w_edge;
`endif

endmodule

// File: rtl/snake_body.sv
// Snake body shift register with IDLE/RUN/DEAD control FSM.
// Edge behaviour selected by SNAKE_WRAP_EN (see snake_next_head).
module snake_body
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 16,
  parameter int COORD_W  = COORD_W_D,
  parameter int FIELD_W  = 30,
  parameter int FIELD_H  = 24,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 8,
  parameter int INIT_Y   = 8
) (
  input logic         clk,
  input logic         rst_n,
  snake_body_if.slave bus
);
  localparam int SEG_W = 2 * COORD_W;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int SNK_W = MAX_LEN * SEG_W;

  function automatic logic [SNK_W-1:0] init_body();
    logic [SNK_W-1:0] b;
    int kk;
    b = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      kk = (k < INIT_LEN) ? k : INIT_LEN - 1;
      b[k*SEG_W +: SEG_W] = {COORD_W'(INIT_Y), COORD_W'(INIT_X - kk)};
    end
    return b;
  endfunction

  localparam logic [SNK_W-1:0] INIT_BODY = init_body();

  state_e           r_state;
  logic [SNK_W-1:0] r_snake;
  logic [LEN_W-1:0] r_len;
  dir_e             r_dir;
  logic             r_grow;
  logic             r_alive;
  logic             r_moved;

  dir_e             w_req;
  dir_e             w_dir;
  logic [SEG_W-1:0] w_head;
  logic             w_out;
  logic             w_grow;
  logic [LEN_W-1:0] w_len;
  logic [IDX_W-1:0] w_tidx;
  logic [SEG_W-1:0] w_sh [MAX_LEN];
  logic [SEG_W-1:0] w_tail;
  logic [SNK_W-1:0] w_next;

  assign w_req  = dir_e'(bus.dir_req);
  assign w_dir  = (w_req == opposite(r_dir)) ? r_dir : w_req;
  assign w_grow = r_grow | bus.grow;
  assign w_len  = (w_grow && r_len != LEN_W'(MAX_LEN)) ?
                  r_len + 1'b1 : r_len;
  assign w_tidx = IDX_W'(w_len - 1'b1);

  snake_next_head #(
    .COORD_W (COORD_W),
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H)
  ) u_next (
    .i_head (r_snake[SEG_W-1:0]),
    .i_dir  (w_dir),
    .o_head (w_head),
    .o_out  (w_out)
  );

  // Shift tailward, then copy the new tail into every unused slot
  always_comb begin
    w_sh[0] = w_head;
    for (int i = 1; i < MAX_LEN; i++)
      w_sh[i] = r_snake[(i-1)*SEG_W +: SEG_W];
    w_tail = w_sh[w_tidx];
    w_next = '0;
    for (int i = 0; i < MAX_LEN; i++)
      w_next[i*SEG_W +: SEG_W] = (LEN_W'(i) < w_len) ? w_sh[i] : w_tail;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_snake <= '0;
      r_len   <= '0;
      r_dir   <= DIR_RIGHT;
      r_grow  <= 1'b0;
      r_alive <= 1'b0;
      r_moved <= 1'b0;
    end else begin
      r_moved <= 1'b0;
      if (bus.start) begin
        r_state <= S_RUN;
        r_snake <= INIT_BODY;
        r_len   <= LEN_W'(INIT_LEN);
        r_dir   <= DIR_RIGHT;
        r_grow  <= 1'b0;
        r_alive <= 1'b1;
      end else begin
        if (bus.grow)
          r_grow <= 1'b1;
        unique case (r_state)
          S_RUN: begin
            if (bus.stop || (bus.tick && w_out)) begin
              r_state <= S_DEAD;
              r_alive <= 1'b0;
            end else if (bus.tick) begin
              r_snake <= w_next;
              r_len   <= w_len;
              r_dir   <= w_dir;
              r_grow  <= 1'b0;
              r_moved <= 1'b1;
            end
          end
          S_IDLE, S_DEAD: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.snake = r_snake;
  assign bus.len   = r_len;
  assign bus.alive = r_alive;
  assign bus.moved = r_moved;

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum segment count.
REQ-002 SHALL have parameter COORD_W, default 5, bits per axis; segment width SEG_W = 2*COORD_W, packed {y,x} with x in the low bits.
REQ-003 SHALL have parameter FIELD_W, default 30, columns; x range 0..FIELD_W-1.
REQ-004 SHALL have parameter FIELD_H, default 24, rows; y range 0..FIELD_H-1.
REQ-005 SHALL have parameters INIT_LEN, default 3, and INIT_X / INIT_Y, default 8 / 8, for the start position.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  pulse: (re)initialise and enter RUN.
REQ-009 SHALL have port tick  input  1  one-cycle move strobe.
REQ-010 SHALL have port dir_req  input  2  requested direction (0 up, 1 right, 2 down, 3 left).
REQ-011 SHALL have port grow  input  1  pulse: lengthen by one at next move.
REQ-012 SHALL have port stop  input  1  collision verdict from the collision checker.
REQ-013 SHALL have port snake  output  MAX_LEN*SEG_W  packed body; segment i at [i*SEG_W +: SEG_W], slot 0 = head.
REQ-014 SHALL have port len  output  $clog2(MAX_LEN+1)  current length.
REQ-015 SHALL have port alive  output  1  high in RUN only.
REQ-016 SHALL have port moved  output  1  one-cycle pulse the cycle after a move is committed.

Function
REQ-017 SHALL implement states IDLE, RUN, DEAD, all outputs registered.
REQ-018 IDLE -> RUN on start; RUN -> DEAD on stop; DEAD -> RUN on start; start in RUN SHALL reinitialise and stay in RUN.
REQ-019 Initialisation SHALL set head (INIT_X,INIT_Y), segment k at (INIT_X-k,INIT_Y) for k<INIT_LEN, len=INIT_LEN, direction right, grow_pending cleared.
REQ-020 Slots with index >= len SHALL replicate the tail segment, so no phantom coordinates appear.
REQ-021 On tick in RUN with stop low, segments SHALL shift one slot tailward and slot 0 SHALL take the next head; snake/len update and moved pulses exactly one cycle after tick.
REQ-022 dir_req SHALL be sampled on every tick; a request exactly opposite the current direction SHALL be ignored.
REQ-023 grow SHALL set grow_pending (multiple pulses before a tick collapse to one); the next move SHALL increment len, saturating at MAX_LEN, and clear grow_pending.
REQ-024 Simultaneous stop and tick SHALL enter DEAD with no move; ticks in IDLE/DEAD SHALL be ignored.
REQ-025 Simultaneous start and stop SHALL give start priority.
REQ-026 Coordinate arithmetic SHALL be COORD_W-bit, compared against FIELD_W/FIELD_H, never 2^COORD_W.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, snake=0, len=0, alive=0, moved=0, grow_pending=0, direction right, including mid-move.
REQ-028 Release SHALL take effect on the first rising clk edge with rst_n high.

Configuration
REQ-029 Macro SNAKE_WRAP_EN defined: a head leaving the field SHALL wrap (x FIELD_W-1 right -> 0, x 0 left -> FIELD_W-1, same for y).
REQ-030 SNAKE_WRAP_EN undefined: a move that would leave the field SHALL enter DEAD with no move committed and no moved pulse.

Structure
REQ-031 Package snake_pkg SHALL hold the direction enum, the state enum, and the COORD_W/SEG_W defaults.
REQ-032 Next-head calculation (move, wrap or out-of-field flag) SHALL be one combinational sub-module, snake_next_head.

Verification
REQ-033 Reset then start -> len=3, slots 0..2 = (8,8),(7,8),(6,8), slots 3..15 = (6,8), alive=1.
REQ-034 tick with dir_req=left while moving right -> head (9,8); reversal ignored; moved pulses one cycle later.
REQ-035 grow, grow, then tick -> len 3->4 only; 13 further grow+tick pairs -> len saturates at 16.
REQ-036 Head (29,5) moving right, tick -> with SNAKE_WRAP_EN head (0,5); without it DEAD, snake unchanged.
REQ-037 stop and tick in the same cycle -> DEAD, snake unchanged, alive=0; later start -> RUN with initial body.
REQ-038 rst_n low asserted between tick and the update edge -> all outputs zero, IDLE, no moved pulse.
